// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters.
// It latches the winner's byte and parity, pulses tx_send, then waits for tx_done (or a timeout) and an idle gap.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_parity,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 busy,
    output logic                 tx_send,
    output logic [7:0]           Tx_data,
    output logic                 parity_sel,
    input  logic                 tx_done
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt, sel, cand;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [TO_W-1:0]  tout_cnt, tout_nxt;
    logic             armed, armed_nxt;
    logic [N_REQ-1:0] gnt_nxt, done_nxt, err_nxt;
    logic             send_nxt;
    logic [7:0]       data_nxt;
    logic             par_nxt;

    // Scan farthest-to-nearest after ptr so the nearest pending requester is what remains in sel.
    always_comb begin
        sel  = ptr;
        cand = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) sel = cand;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        gap_nxt   = gap_cnt;
        tout_nxt  = tout_cnt;
        armed_nxt = armed;
        data_nxt  = Tx_data;
        par_nxt   = parity_sel;
        gnt_nxt   = '0;
        done_nxt  = '0;
        err_nxt   = '0;
        send_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt[sel] = 1'b1;
                    ptr_nxt      = sel;
                    data_nxt     = req_data[{sel, 3'b000} +: 8];
                    par_nxt      = req_parity[sel];
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                send_nxt  = 1'b1;
                armed_nxt = 1'b0;
                tout_nxt  = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done is only trusted after it has been seen low, since it idles high.
                if (tx_done && armed) begin
                    done_nxt[ptr] = 1'b1;
                    gap_nxt       = '0;
                    state_nxt     = GAP;
                end else if (tout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt[ptr] = 1'b1;
                    gap_nxt      = '0;
                    state_nxt    = GAP;
                end else begin
                    tout_nxt = tout_cnt + TO_W'(1);
                    if (!tx_done) armed_nxt = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
                else gap_nxt = gap_cnt + GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= PTR_W'(N_REQ - 1);
            gap_cnt    <= '0;
            tout_cnt   <= '0;
            armed      <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            tx_send    <= 1'b0;
            Tx_data    <= 8'h00;
            parity_sel <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gap_cnt    <= gap_nxt;
            tout_cnt   <= tout_nxt;
            armed      <= armed_nxt;
            gnt        <= gnt_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            tx_send    <= send_nxt;
            Tx_data    <= data_nxt;
            parity_sel <= par_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table-driven grant sequences, multi-cycle corner cases,
// and randomized transactions checked against a round-robin model and a simple transmitter model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int G = 16;
    localparam int T = 300;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_parity;
    logic [N-1:0]   gnt, done, err;
    logic           busy, tx_send, parity_sel, tx_done;
    logic [7:0]     Tx_data;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_parity (req_parity),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .tx_send    (tx_send),
        .Tx_data    (Tx_data),
        .parity_sel (parity_sel),
        .tx_done    (tx_done)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int model_ptr = N - 1;

    // Transmitter model state: drops tx_done 2 cycles after seeing tx_send, raises it tx_len cycles later.
    bit tx_stuck;
    int tx_len;
    int tx_phase;
    int tx_rise_cyc;

    typedef struct {
        logic [N-1:0] req;
        int           exp_idx;
        logic [7:0]   base;
        logic [N-1:0] par;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tx_done     = 1'b1;
        tx_phase    = -1;
        tx_rise_cyc = -1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                tx_phase = -1;
                tx_done  = 1'b1;
            end else if (tx_phase < 0) begin
                if (tx_send && !tx_stuck) tx_phase = 0;
            end else begin
                tx_phase++;
                if (tx_phase == 2) tx_done = 1'b0;
                if (tx_phase == 2 + tx_len) begin
                    tx_done     = 1'b1;
                    tx_rise_cyc = cyc;
                    tx_phase    = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no response within the cycle bound", name);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Reference arbitration: first set request after the last grant, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int           j;
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            t = r >> j;
            if (t[0]) return j;
        end
        return -1;
    endfunction

    task automatic check_reset(input string name);
        check({name, "_gnt"},    32'(gnt),        32'h0);
        check({name, "_done"},   32'(done),       32'h0);
        check({name, "_err"},    32'(err),        32'h0);
        check({name, "_busy"},   32'(busy),       32'h0);
        check({name, "_send"},   32'(tx_send),    32'h0);
        check({name, "_data"},   32'(Tx_data),    32'h0);
        check({name, "_parity"}, 32'(parity_sel), 32'h0);
    endtask

    task automatic wait_idle(input string name, output int c);
        bit got;
        got = 0;
        c   = -1;
        for (int k = 0; k < 1000 && !got; k++) begin
            step();
            if (!busy) begin
                got = 1;
                c   = cyc;
            end
        end
        if (!got) report_timeout(name);
    endtask

    // One complete transaction from an idle arbiter: grant, send, completion, gap.
    task automatic run_txn(input string name, input logic [N-1:0] r, input int exp_idx,
                           input logic [8*N-1:0] data, input logic [N-1:0] par,
                           input logic [8*N-1:0] post_data, input int len);
        int         start_cyc, gnt_cyc, idle_cyc;
        bit         got, stable;
        logic [7:0] exp_d;
        logic       exp_p;
        exp_d      = 8'(data >> (8 * exp_idx));
        exp_p      = 1'(par >> exp_idx);
        tx_len     = len;
        req_data   = data;
        req_parity = par;
        req        = r;
        start_cyc  = cyc;
        got        = 0;
        gnt_cyc    = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            step();
            if (gnt != '0) begin
                got     = 1;
                gnt_cyc = cyc;
            end
        end
        if (!got) begin
            report_timeout({name, "_gnt_wait"});
            req = '0;
            return;
        end
        check({name, "_gnt"},     32'(gnt),              32'(onehot(exp_idx)));
        check({name, "_lat"},     32'(gnt_cyc - start_cyc), 32'd1);
        check({name, "_data"},    32'(Tx_data),          32'(exp_d));
        check({name, "_parity"},  32'(parity_sel),       32'(exp_p));
        check({name, "_send0"},   32'(tx_send),          32'h0);
        req        = '0;
        req_data   = post_data;
        req_parity = ~par;
        step();
        check({name, "_send1"},   32'(tx_send),          32'h1);
        check({name, "_gnt_off"}, 32'(gnt),              32'h0);
        got    = 0;
        stable = 1;
        for (int k = 0; k < T + 200 && !got; k++) begin
            step();
            if (Tx_data !== exp_d || parity_sel !== exp_p) stable = 0;
            if (done != '0 || err != '0) got = 1;
        end
        if (!got) begin
            report_timeout({name, "_done_wait"});
            return;
        end
        check({name, "_done"},     32'(done),             32'(onehot(exp_idx)));
        check({name, "_no_err"},   32'(err),              32'h0);
        check({name, "_done_cyc"}, 32'(cyc - tx_rise_cyc), 32'd1);
        check({name, "_held"},     32'(stable),           32'h1);
        wait_idle({name, "_idle_wait"}, idle_cyc);
        // Completion is seen one edge after the tx_done rise, then GAP lasts G cycles.
        check({name, "_busy_drop"}, 32'(idle_cyc - tx_rise_cyc), 32'(G + 1));
    endtask

    initial begin
        vec_t           vecs[$];
        logic [8*N-1:0] d;
        logic [N-1:0]   r, p;
        int             e, gidx, gc, prev_gc, c, err_cyc;
        bit             got, quiet;

        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        req_parity = '0;
        tx_stuck   = 1'b0;
        tx_len     = 100;
        repeat (3) step();
        check_reset("por");
        rst = 1'b0;
        step();
        check("por_idle_busy", 32'(busy), 32'h0);

        // Basic single transfer with a long transmitter occupancy.
        run_txn("basic", 4'b0001, 0, 32'h0000_00A5, 4'b0001, 32'hFFFF_FFFF, 100);
        model_ptr = 0;

        // Grant sequences with hand-derived expectations, starting after a grant to requester 0.
        vecs.push_back('{4'b1111, 1, 8'h10, 4'b0101});
        vecs.push_back('{4'b1111, 2, 8'h20, 4'b1010});
        vecs.push_back('{4'b1111, 3, 8'h30, 4'b1100});
        vecs.push_back('{4'b1111, 0, 8'h40, 4'b0011});
        vecs.push_back('{4'b0010, 1, 8'h50, 4'b0010});
        vecs.push_back('{4'b1001, 3, 8'h60, 4'b1000});
        vecs.push_back('{4'b1001, 0, 8'h70, 4'b0000});
        vecs.push_back('{4'b0001, 0, 8'h80, 4'b0001});
        vecs.push_back('{4'b0100, 2, 8'h90, 4'b0100});
        vecs.push_back('{4'b0011, 0, 8'hA0, 4'b1110});
        vecs.push_back('{4'b0110, 1, 8'hB0, 4'b0010});
        vecs.push_back('{4'b1000, 3, 8'hC0, 4'b0111});
        foreach (vecs[i]) begin
            for (int k = 0; k < N; k++) d[8*k +: 8] = vecs[i].base + 8'(k);
            run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].exp_idx, d, vecs[i].par, ~d, 4);
            model_ptr = vecs[i].exp_idx;
        end

        // All requesters held high: strict rotation and minimum grant spacing.
        tx_len   = 6;
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        prev_gc  = -1;
        for (int i = 0; i < 5; i++) begin
            got = 0;
            gc  = -1;
            for (int k = 0; k < 500 && !got; k++) begin
                step();
                if (gnt != '0) begin
                    got = 1;
                    gc  = cyc;
                end
            end
            if (!got) begin
                report_timeout($sformatf("rot%0d_wait", i));
                break;
            end
            e = rr_pick(4'b1111, model_ptr);
            check($sformatf("rot%0d_gnt", i), 32'(gnt), 32'(onehot(e)));
            model_ptr = e;
            // WAIT_DONE lasts the tx_send cycle, 2 cycles until tx_done drops, and tx_len low cycles.
            if (prev_gc >= 0)
                check($sformatf("rot%0d_spacing", i), 32'(gc - prev_gc), 32'(1 + (tx_len + 3) + G + 1));
            prev_gc = gc;
        end
        req = '0;
        wait_idle("rot_idle_wait", c);

        // Transmitter never responds: watchdog abort, then normal service resumes.
        tx_stuck = 1'b1;
        e        = rr_pick(4'b0010, model_ptr);
        req      = 4'b0010;
        step();
        check("to_gnt", 32'(gnt), 32'(onehot(e)));
        gc  = cyc;
        req = '0;
        got = 0;
        err_cyc = -1;
        for (int k = 0; k < T + 100 && !got; k++) begin
            step();
            if (done != '0 || err != '0) begin
                got     = 1;
                err_cyc = cyc;
            end
        end
        if (!got) report_timeout("to_err_wait");
        else begin
            check("to_err",     32'(err),            32'(onehot(e)));
            check("to_no_done", 32'(done),           32'h0);
            check("to_err_cyc", 32'(err_cyc - gc),   32'(T + 1));
            wait_idle("to_idle_wait", c);
            check("to_gap",     32'(c - err_cyc),    32'(G));
        end
        model_ptr = e;
        tx_stuck  = 1'b0;
        e = rr_pick(4'b0010, model_ptr);
        run_txn("after_to", 4'b0010, e, 32'h1234_5678, 4'b0010, 32'h8765_4321, 5);
        model_ptr = e;

        // Reset in the middle of WAIT_DONE drops the byte silently and restarts the pointer.
        tx_len   = 100;
        e        = rr_pick(4'b0010, model_ptr);
        req_data = 32'h5566_7788;
        req      = 4'b0010;
        step();
        check("mid_gnt", 32'(gnt), 32'(onehot(e)));
        req = '0;
        repeat (10) step();
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        check_reset("mid_rst");
        rst   = 1'b0;
        quiet = 1;
        repeat (150) begin
            step();
            if (done != '0 || err != '0 || busy) quiet = 0;
        end
        check("mid_quiet", 32'(quiet), 32'h1);
        model_ptr = N - 1;
        e = rr_pick(4'b0110, model_ptr);
        run_txn("rst_scan", 4'b0110, e, 32'h0102_0304, 4'b0000, 32'h0, 3);
        model_ptr = e;

        // Requester 2 changes its byte right after the grant; the byte in flight must not change.
        e = rr_pick(4'b0100, model_ptr);
        run_txn("hold_3c", 4'b0100, e, 32'h003C_0000, 4'b0100, 32'hFFFF_FFFF, 20);
        model_ptr = e;

        // Randomized transactions against the round-robin model.
        for (int i = 0; i < 20; i++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            d = $urandom;
            p = N'($urandom);
            e = rr_pick(r, model_ptr);
            run_txn($sformatf("rnd%0d", i), r, e, d, p, $urandom, $urandom_range(1, 12));
            model_ptr = e;
            repeat ($urandom_range(0, 3)) step();
        end

        gidx = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
